// File: rtl/jk_to_sr_d_t_conversion.sv
// SR, D and T flip-flops built on JK cores, with illegal S=R=1 counting and self-check (SR_ILLEGAL_HOLD_EN selects S=R=1 hold).
// Latency: q*/illegal/illegal_cnt 1 cycle, err one cycle later; no backpressure, en=0 holds every flop.

module jk_core (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else begin
            q <= (j & ~q) | (~k & q);
        end
    end
endmodule

module jk_to_sr_d_t_conversion #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             d,
    input  logic             t,
    output logic             qsr,
    output logic             qbsr,
    output logic             qd,
    output logic             qbd,
    output logic             qt,
    output logic             qbt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic             err
);
    logic j_sr, k_sr, j_d, k_d, j_t, k_t;
    logic qsr_ref, qd_ref, qt_ref;
    logic mismatch;

`ifdef SR_ILLEGAL_HOLD_EN
    assign j_sr = en & s & ~r;
    assign k_sr = en & r & ~s;
`else
    assign j_sr = en & s;
    assign k_sr = en & r;
`endif
    assign j_d = en & d;
    assign k_d = en & ~d;
    assign j_t = en & t;
    assign k_t = en & t;

    jk_core u_sr (.clk(clk), .reset(reset), .j(j_sr), .k(k_sr), .q(qsr));
    jk_core u_d  (.clk(clk), .reset(reset), .j(j_d),  .k(k_d),  .q(qd));
    jk_core u_t  (.clk(clk), .reset(reset), .j(j_t),  .k(k_t),  .q(qt));

    // Complements come straight off the same register, so they can never lag.
    assign qbsr = ~qsr;
    assign qbd  = ~qd;
    assign qbt  = ~qt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            illegal <= en & s & r;
            if (en && s && r && (illegal_cnt != {CNT_W{1'b1}})) begin
                illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qsr_ref <= 1'b0;
            qd_ref  <= 1'b0;
            qt_ref  <= 1'b0;
        end else if (en) begin
            qd_ref <= d;
            qt_ref <= qt_ref ^ t;
            case ({s, r})
                2'b10:   qsr_ref <= 1'b1;
                2'b01:   qsr_ref <= 1'b0;
`ifdef SR_ILLEGAL_HOLD_EN
                2'b11:   qsr_ref <= qsr_ref;
`else
                2'b11:   qsr_ref <= ~qsr_ref;
`endif
                default: qsr_ref <= qsr_ref;
            endcase
        end
    end

    assign mismatch = (qsr != qsr_ref) | (qd != qd_ref) | (qt != qt_ref);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else begin
            err <= err | mismatch;
        end
    end
endmodule

// File: tb/tb_jk_to_sr_d_t_conversion.sv
// Randomized and directed bench for jk_to_sr_d_t_conversion against a rule-level reference model.
module tb_jk_to_sr_d_t_conversion;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef SR_ILLEGAL_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, en, s, r, d, t;
    logic qsr, qbsr, qd, qbd, qt, qbt, illegal, err;
    logic [CNT_W-1:0] illegal_cnt;

    int checks = 0;
    int errors = 0;

    bit m_qsr, m_qd, m_qt, m_ill;
    int m_cnt;

    jk_to_sr_d_t_conversion #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .en(en), .s(s), .r(r), .d(d), .t(t),
        .qsr(qsr), .qbsr(qbsr), .qd(qd), .qbd(qbd), .qt(qt), .qbt(qbt),
        .illegal(illegal), .illegal_cnt(illegal_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".qsr"},  32'(qsr),  32'(m_qsr));
        check({tag, ".qbsr"}, 32'(qbsr), 32'(!m_qsr));
        check({tag, ".qd"},   32'(qd),   32'(m_qd));
        check({tag, ".qbd"},  32'(qbd),  32'(!m_qd));
        check({tag, ".qt"},   32'(qt),   32'(m_qt));
        check({tag, ".qbt"},  32'(qbt),  32'(!m_qt));
        check({tag, ".ill"},  32'(illegal), 32'(m_ill));
        check({tag, ".cnt"},  32'(illegal_cnt), 32'(m_cnt));
        check({tag, ".err"},  32'(err),  32'd0);
    endtask

    task automatic model_reset();
        m_qsr = 0; m_qd = 0; m_qt = 0; m_ill = 0; m_cnt = 0;
    endtask

    // Inputs change after the falling edge; outputs are compared on the next falling edge.
    task automatic step(input string tag, input bit e, input bit ss, input bit rr,
                        input bit dd, input bit tt);
        en = e; s = ss; r = rr; d = dd; t = tt;
        @(posedge clk);
        if (e) begin
            m_qd = dd;
            m_qt = m_qt ^ tt;
            if (ss && !rr)      m_qsr = 1;
            else if (!ss && rr) m_qsr = 0;
            else if (ss && rr)  m_qsr = HOLD ? m_qsr : !m_qsr;
            m_ill = ss && rr;
            if (ss && rr && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end else begin
            m_ill = 0;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; en = 0; s = 0; r = 0; d = 0; t = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("rst");
        reset = 1'b1;
        repeat (3) step("hold", 0, 0, 0, 0, 0);

        step("d1", 1, 0, 0, 1, 0);
        step("d2", 1, 0, 0, 0, 0);
        step("d3", 1, 0, 0, 1, 0);
        step("d4", 1, 0, 0, 1, 0);

        step("t1", 1, 0, 0, 1, 1);
        step("t2", 1, 0, 0, 1, 1);
        step("t3", 1, 0, 0, 1, 0);
        step("t4", 1, 0, 0, 1, 1);

        step("sr1", 1, 1, 0, 1, 0);
        step("sr2", 1, 0, 0, 1, 0);
        step("sr3", 1, 0, 1, 1, 0);
        step("sr4", 1, 1, 1, 1, 0);
        check("sr4.qsr_abs", 32'(qsr), HOLD ? 32'd0 : 32'd1);
        step("sr5", 1, 0, 0, 1, 0);
        check("sr5.cnt_abs", 32'(illegal_cnt), 32'd1);

        async_reset("rst2");
        for (int i = 0; i < 5; i++) step($sformatf("sat%0d", i), 1, 1, 1, 0, 0);
        check("sat.cnt_abs", 32'(illegal_cnt), 32'd3);

        async_reset("rst3");
        step("post_rst", 0, 1, 1, 0, 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset($sformatf("rrst%0d", i));
            end
            step($sformatf("rnd%0d", i), $urandom_range(0, 3) != 0,
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/jk_to_sr_d_t_conversion.md
# jk_to_sr_d_t_conversion

Builds SR, D and T flip-flops from a common JK flip-flop core. Each target flop drives its own JK cell through fixed excitation logic. The block also counts illegal S=R=1 requests and self-checks every converted flop against a direct behavioural model each cycle. It is the reverse direction of the existing SR/T/D-to-JK conversion block and shares its flip-flop library and bench style.

## Interface
Parameters:
- CNT_W, 4, width of the illegal-request counter (saturating)

Ports:
- clk  in  1  rising-edge clock for all state
- reset  in  1  asynchronous, active-low; all state is cleared while low
- en  in  1  clock enable for all three converted flops; low means every flop holds
- s  in  1  SR set input
- r  in  1  SR reset input
- d  in  1  D data input
- t  in  1  T toggle input
- qsr, qbsr  out  1 each  SR-flop output and its complement
- qd, qbd  out  1 each  D-flop output and its complement
- qt, qbt  out  1 each  T-flop output and its complement
- illegal  out  1  registered; high for one cycle after an enabled S=R=1 sample
- illegal_cnt  out  CNT_W  count of enabled S=R=1 samples; saturates
- err  out  1  sticky; set when any converted output differs from its behavioural model

## Operation
- JK core: next q = J&~q | ~K&q. This gives hold (00), reset (01), set (10) and toggle (11).
- Excitation per target:
  - SR: J=s, K=r.
  - D: J=d, K=~d.
  - T: J=t, K=t.
- When en=0, J and K are forced to 0 in all three cores. Every flop then holds.
- Every qb* output is the exact complement of its q*. No glitch or lag is allowed between q* and qb*.
- Illegal detection: en&s&r sampled at a rising edge does two things on that same edge:
  - sets illegal=1 for exactly one cycle;
  - increments illegal_cnt, stopping at 2^CNT_W-1 with no wrap.
- Behavioural models run in parallel:
  - D model: qd_ref<=d.
  - T model: qt_ref<=qt_ref^t.
  - SR model: set/reset/hold. S=R=1 is handled per the Configuration section.
  - All models are gated by en.
- Comparison happens after each edge. If any (q*, q*_ref) pair differs, err sets on the next edge and stays 1 until reset.

## Timing
- Reset values while reset=0: qsr=qd=qt=0, qbsr=qbd=qbt=1, all model registers 0, illegal=0, illegal_cnt=0, err=0.
- Reset assertion takes effect immediately, independent of clk.
- Reset deassertion is sampled at the next rising edge. The first state update occurs on the first edge with reset=1.
- Latency:
  - q* reflects inputs sampled at edge N, right after edge N.
  - illegal and illegal_cnt also update at edge N.
  - err reports a mismatch from edge N at edge N+1.
- Simultaneous events:
  - S=R=1 with en=0 is neither counted nor flagged.
  - A counter at saturation still pulses illegal.
- Reset asserted mid-operation clears err and the counter regardless of pending mismatch.

## Configuration
- SR_ILLEGAL_HOLD_EN defined:
  - S=R=1 forces J=K=0 on the SR core, so qsr holds.
  - The SR model also holds.
- SR_ILLEGAL_HOLD_EN undefined:
  - S=R=1 passes straight to the JK core, so qsr toggles (native JK behaviour).
  - The SR model also toggles.
- In both builds, illegal and illegal_cnt behave identically, and err stays 0 for a correct implementation.

## Test plan
- Reset and hold check:
  - Hold reset=0 for 2 edges, then release with en=0 and s=r=d=t=0 for 3 edges.
  - Required: all q*=0, qb*=1, illegal_cnt=0, err=0 throughout.
- D path:
  - With en=1, drive d=1,0,1,1 on successive edges.
  - Required: qd=1,0,1,1 after each edge; qbd is the complement.
- T path:
  - Start from qt=0 with en=1 and drive t=1,1,0,1.
  - Required: qt=1,0,0,1.
- SR path:
  - Drive (s,r)=(1,0),(0,0),(0,1),(1,1).
  - Required: qsr=1,1,0, then after the fourth edge 0 with macro defined or 1 without.
  - Required: illegal=1 for one cycle only; illegal_cnt=1.
- Saturation with CNT_W=2:
  - Apply s=r=1 with en=1 for 5 edges.
  - Required: illegal_cnt=1,2,3,3,3; illegal stays high on all 5 cycles; err=0.
- Async reset mid-run:
  - After the saturation scenario, drop reset between edges.
  - Required: illegal_cnt=0, qsr=0 and qbsr=1 before the next edge.
  - Required: en=0 with s=r=1 after release leaves illegal_cnt=0.
